// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction memory loader:
// state encoding, stream framing constants and a state classification helper.
package imem_loader_pkg;

   localparam logic [2:0] ST_HDR0  = 3'd0;
   localparam logic [2:0] ST_HDR1  = 3'd1;
   localparam logic [2:0] ST_DATA  = 3'd2;
   localparam logic [2:0] ST_CHECK = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;
   localparam logic [2:0] ST_ERROR = 3'd5;

   localparam int         BYTES_PER_WORD = 4;
   localparam int         HDR_BYTES      = 2;
   localparam logic [7:0] CHECKSUM_INIT  = 8'h00;

   // States in which the loader still consumes stream bytes.
   function automatic logic accepts_bytes(input logic [2:0] st);
      return (st == ST_HDR0) || (st == ST_HDR1) || (st == ST_DATA) || (st == ST_CHECK);
   endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Gathers stream bytes LSB-first into a word and presents it with a one-cycle
// valid pulse on the cycle after its last byte arrives.
module imem_loader_byte_packer
   import imem_loader_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        i_clear,
   input  logic        i_accept,
   input  logic [7:0]  i_byte,
   output logic [31:0] o_word,
   output logic        o_word_valid,
   output logic        o_last
);

   localparam int CNT_W = $clog2(BYTES_PER_WORD);
   localparam int ACC_W = 8 * (BYTES_PER_WORD - 1);

   logic [CNT_W-1:0] r_cnt;
   logic [ACC_W-1:0] r_acc;
   logic [31:0]      r_word;
   logic             r_word_valid;
   logic             w_last;

   assign w_last       = (r_cnt == CNT_W'(BYTES_PER_WORD - 1));
   assign o_last       = w_last;
   assign o_word       = r_word;
   assign o_word_valid = r_word_valid;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_cnt        <= '0;
         r_word       <= '0;
         r_word_valid <= 1'b0;
      end else begin
         r_word_valid <= 1'b0;
         if (i_clear) begin
            r_cnt <= '0;
         end else if (i_accept) begin
            if (w_last) begin
               r_word       <= {i_byte, r_acc};
               r_word_valid <= 1'b1;
               r_cnt        <= '0;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end
      end
   end

   // Lower bytes need no reset: a word is only emitted once all of them are refilled.
   always_ff @(posedge clock) begin
      if (i_accept && !i_clear && !w_last) begin
         r_acc[{r_cnt, 3'b000} +: 8] <= i_byte;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a length-prefixed byte stream, writes the payload words to
// imem from address 0 and releases the CPU only after the XOR checksum matches.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [7:0]            byte_in,
   input  logic                  byte_valid,
   output logic                  byte_ready,
   output logic                  imem_wren,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [DATA_WIDTH-1:0] imem_data,
   output logic                  cpu_reset,
   output logic                  load_done,
   output logic                  load_error,
   output logic [ADDR_WIDTH:0]   words_loaded
);

   localparam logic [16:0] CAPACITY = 17'(2 ** ADDR_WIDTH);

   logic [2:0]            r_state;
   logic [2:0]            w_next;
   logic                  r_ready;
   logic [7:0]            r_n_lo;
   logic [ADDR_WIDTH:0]   r_n;
   logic [ADDR_WIDTH:0]   r_wacc;
   logic [7:0]            r_xor;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [ADDR_WIDTH:0]   r_words;
   logic                  r_done;
   logic                  r_error;
   logic                  r_cpu_reset;

   logic                  w_xfer;
   logic                  w_pack_accept;
   logic                  w_pack_clear;
   logic                  w_pack_last;
   logic [31:0]           w_word;
   logic                  w_word_valid;
   logic [15:0]           w_n_full;
   logic                  w_word_done;
   logic                  w_final_word;

   assign w_xfer        = byte_valid & r_ready;
   assign w_pack_accept = w_xfer && (r_state == ST_DATA);
   assign w_pack_clear  = (r_state == ST_HDR0);
   assign w_n_full      = {byte_in, r_n_lo};
   assign w_word_done   = w_pack_accept && w_pack_last;
   assign w_final_word  = w_word_done && ((r_wacc + 1'b1) == r_n);

   imem_loader_byte_packer u_packer (
      .clock        (clock),
      .reset        (reset),
      .i_clear      (w_pack_clear),
      .i_accept     (w_pack_accept),
      .i_byte       (byte_in),
      .o_word       (w_word),
      .o_word_valid (w_word_valid),
      .o_last       (w_pack_last)
   );

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_HDR0:  if (w_xfer) w_next = ST_HDR1;
         ST_HDR1: begin
            if (w_xfer) begin
               if ({1'b0, w_n_full} > CAPACITY) w_next = ST_ERROR;
               else if (w_n_full == 16'd0)      w_next = ST_CHECK;
               else                             w_next = ST_DATA;
            end
         end
         ST_DATA:  if (w_final_word) w_next = ST_CHECK;
         ST_CHECK: if (w_xfer) w_next = (byte_in == r_xor) ? ST_DONE : ST_ERROR;
         ST_DONE:  w_next = ST_DONE;
         ST_ERROR: w_next = ST_ERROR;
         default:  w_next = ST_ERROR;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state     <= ST_HDR0;
         r_ready     <= 1'b0;
         r_done      <= 1'b0;
         r_error     <= 1'b0;
         r_cpu_reset <= 1'b1;
      end else begin
         r_state     <= w_next;
         r_ready     <= accepts_bytes(w_next);
         r_done      <= r_done  | (w_next == ST_DONE);
         r_error     <= r_error | (w_next == ST_ERROR);
         r_cpu_reset <= (w_next != ST_DONE);
      end
   end

   // Header length, word count and checksum for the image being received.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_n_lo <= '0;
         r_n    <= '0;
         r_wacc <= '0;
         r_xor  <= CHECKSUM_INIT;
      end else begin
         if (r_state == ST_HDR0) begin
            r_wacc <= '0;
            r_xor  <= CHECKSUM_INIT;
            if (w_xfer) r_n_lo <= byte_in;
         end
         if ((r_state == ST_HDR1) && w_xfer) r_n <= w_n_full[ADDR_WIDTH:0];
         if (w_pack_accept) begin
            r_xor <= r_xor ^ byte_in;
            if (w_pack_last) r_wacc <= r_wacc + 1'b1;
         end
      end
   end

   // Address and count advance the cycle after each write; the final wrap is harmless.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_addr  <= '0;
         r_words <= '0;
      end else if (w_word_valid) begin
         r_addr  <= r_addr + 1'b1;
         r_words <= r_words + 1'b1;
      end
   end

   assign byte_ready   = r_ready;
   assign imem_wren    = w_word_valid;
   assign imem_addr    = r_addr;
   assign imem_data    = w_word;
   assign cpu_reset    = r_cpu_reset;
   assign load_done    = r_done;
   assign load_error   = r_error;
   assign words_loaded = r_words;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: streams whole images, predicts writes and final
// status from the stream format, and checks every write and status each cycle.
module tb_imem_loader;

   logic        clock = 1'b0;
   logic        reset;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic        byte_ready;
   logic        imem_wren;
   logic [11:0] imem_addr;
   logic [31:0] imem_data;
   logic        cpu_reset;
   logic        load_done;
   logic        load_error;
   logic [12:0] words_loaded;

   imem_loader dut (
      .clock        (clock),
      .reset        (reset),
      .byte_in      (byte_in),
      .byte_valid   (byte_valid),
      .byte_ready   (byte_ready),
      .imem_wren    (imem_wren),
      .imem_addr    (imem_addr),
      .imem_data    (imem_data),
      .cpu_reset    (cpu_reset),
      .load_done    (load_done),
      .load_error   (load_error),
      .words_loaded (words_loaded)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [11:0] a;
      logic [31:0] d;
   } wr_t;

   int          vectors = 0;
   int          fails   = 0;
   wr_t         exp_q[$];
   logic [7:0]  stim[$];
   logic [31:0] mem [0:4095];
   logic        exp_done;
   logic        exp_err;
   int          exp_words;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Expected writes and outcome for the first len bytes of stim.
   task automatic model_stream(input int len);
      int         n;
      logic [7:0] ck;
      logic [31:0] w;
      exp_done  = 1'b0;
      exp_err   = 1'b0;
      exp_words = 0;
      if (len < 2) return;
      n = int'({stim[1], stim[0]});
      if (n > 4096) begin
         exp_err = 1'b1;
         return;
      end
      for (int k = 0; k < n; k++) begin
         if (2 + 4*k + 3 >= len) break;
         w = {stim[2+4*k+3], stim[2+4*k+2], stim[2+4*k+1], stim[2+4*k]};
         exp_q.push_back('{a: 12'(k), d: w});
         exp_words++;
      end
      ck = 8'h00;
      for (int j = 0; j < 4*n && 2 + j < len; j++) ck ^= stim[2+j];
      if (len >= 2 + 4*n + 1) begin
         if (stim[2+4*n] == ck) exp_done = 1'b1;
         else                   exp_err  = 1'b1;
      end
   endtask

   always @(negedge clock) begin
      if (!reset) begin
         if (imem_wren) begin
            if (exp_q.size() == 0) begin
               vectors++;
               fails++;
               $display("FAIL wren_unexpected: write to 0x%0h data 0x%0h, expected no write", imem_addr, imem_data);
            end else begin
               wr_t e;
               e = exp_q.pop_front();
               chk("wr_addr", 32'(imem_addr), 32'(e.a));
               chk("wr_data", imem_data, e.d);
            end
            mem[imem_addr] = imem_data;
         end
         chk("cpu_reset_vs_done", 32'(cpu_reset), 32'(!load_done));
         if (load_done || load_error) chk("ready_after_end", 32'(byte_ready), 32'd0);
      end
   end

   task automatic do_reset();
      reset      = 1'b1;
      byte_valid = 1'b0;
      exp_q.delete();
      mem[0] = '0;
      mem[1] = '0;
      mem[4095] = '0;
      #2;
      chk("rst_ready", 32'(byte_ready), 32'd0);
      chk("rst_wren",  32'(imem_wren),  32'd0);
      chk("rst_addr",  32'(imem_addr),  32'd0);
      chk("rst_data",  imem_data,       32'd0);
      chk("rst_done",  32'(load_done),  32'd0);
      chk("rst_err",   32'(load_error), 32'd0);
      chk("rst_words", 32'(words_loaded), 32'd0);
      chk("rst_cpu",   32'(cpu_reset),  32'd1);
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      chk("rel_ready_low", 32'(byte_ready), 32'd0);
      @(posedge clock);
      #1 chk("rel_ready_high", 32'(byte_ready), 32'd1);
   endtask

   task automatic send_stream(input int len, input bit gaps);
      bit got;
      int cnt;
      for (int i = 0; i < len; i++) begin
         if (gaps) begin
            int g;
            g = $urandom_range(0, 3);
            repeat (g) begin
               byte_valid = 1'b0;
               byte_in    = ($urandom_range(0, 1) == 1) ? stim[i] : 8'($urandom);
               @(posedge clock);
               #1;
            end
         end
         byte_valid = 1'b1;
         byte_in    = stim[i];
         got = 1'b0;
         cnt = 0;
         while (!got) begin
            @(negedge clock);
            got = byte_ready;
            @(posedge clock);
            #1;
            cnt++;
            if (!got && cnt >= 50) begin
               vectors++;
               fails++;
               $display("FAIL stream_stall: byte %0d never accepted, byte_ready 0, expected 1", i);
               byte_valid = 1'b0;
               return;
            end
         end
      end
      byte_valid = 1'b0;
   endtask

   task automatic final_check(input string nm);
      repeat (3) @(posedge clock);
      #1;
      chk({nm, "_done"},  32'(load_done),  32'(exp_done));
      chk({nm, "_err"},   32'(load_error), 32'(exp_err));
      chk({nm, "_cpu"},   32'(cpu_reset),  32'(!exp_done));
      chk({nm, "_ready"}, 32'(byte_ready), 32'(!(exp_done || exp_err)));
      chk({nm, "_words"}, 32'(words_loaded), 32'(exp_words));
      chk({nm, "_pending"}, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic load_t1(input logic [7:0] ck);
      stim = '{8'h02, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'hDD, 8'hCC, 8'hBB, 8'hAA, ck};
   endtask

   initial begin
      reset      = 1'b1;
      byte_valid = 1'b0;
      byte_in    = 8'h00;
      do_reset();

      // 1: two words, good checksum
      load_t1(8'h44);
      model_stream(stim.size());
      chk("model_w0", exp_q[0].d, 32'h11223344);
      chk("model_w1", exp_q[1].d, 32'hAABBCCDD);
      send_stream(stim.size(), 1'b0);
      final_check("t1");
      chk("t1_mem0", mem[0], 32'h11223344);
      chk("t1_mem1", mem[1], 32'hAABBCCDD);
      chk("t1_words_lit", 32'(words_loaded), 32'd2);

      // 2: empty image
      do_reset();
      stim = '{8'h00, 8'h00, 8'h00};
      model_stream(stim.size());
      send_stream(stim.size(), 1'b0);
      final_check("t2");
      chk("t2_done_lit", 32'(load_done), 32'd1);

      // 3: bad checksum
      do_reset();
      load_t1(8'h45);
      model_stream(stim.size());
      send_stream(stim.size(), 1'b0);
      final_check("t3");
      chk("t3_err_lit", 32'(load_error), 32'd1);
      chk("t3_mem1", mem[1], 32'hAABBCCDD);

      // 4a: oversized header
      do_reset();
      stim = '{8'h01, 8'h10};
      model_stream(stim.size());
      send_stream(stim.size(), 1'b0);
      final_check("t4a");

      // 4b: full capacity
      do_reset();
      begin
         logic [7:0] ck;
         logic [7:0] b;
         stim.delete();
         stim.push_back(8'h00);
         stim.push_back(8'h10);
         ck = 8'h00;
         for (int j = 0; j < 16384; j++) begin
            b = 8'(j) ^ 8'(j >> 8);
            stim.push_back(b);
            ck ^= b;
         end
         stim.push_back(ck);
      end
      model_stream(stim.size());
      send_stream(stim.size(), 1'b0);
      final_check("t4b");
      chk("t4b_last_word", mem[4095], 32'hC0C1C2C3);
      chk("t4b_words_lit", 32'(words_loaded), 32'h1000);
      chk("t4b_addr_wrap", 32'(imem_addr), 32'd0);

      // 5: test 1 with valid bubbles
      do_reset();
      load_t1(8'h44);
      model_stream(stim.size());
      send_stream(stim.size(), 1'b1);
      final_check("t5");
      chk("t5_mem0", mem[0], 32'h11223344);
      chk("t5_mem1", mem[1], 32'hAABBCCDD);

      // 6: reset after 5 payload bytes, then full resend
      do_reset();
      load_t1(8'h44);
      model_stream(7);
      send_stream(7, 1'b0);
      chk("t6_partial_writes", 32'(exp_q.size()), 32'd0);
      chk("t6_partial_words", 32'(words_loaded), 32'd1);
      do_reset();
      model_stream(stim.size());
      send_stream(stim.size(), 1'b0);
      final_check("t6");
      chk("t6_mem0", mem[0], 32'h11223344);
      chk("t6_mem1", mem[1], 32'hAABBCCDD);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
